// File: rtl/gpu_mem_arbiter_pkg.sv
// Shared types and constants for the GPU SDRAM arbiter.
package gpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT_DATA
    } arb_state_e;

    localparam int AVALON_DATA_BITS = 8;
    localparam int WATCHDOG_BITS    = 8;

endpackage

// File: rtl/gpu_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_REQ.
module gpu_mem_arbiter_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [REQ_BITS-1:0] last,
    output logic [REQ_BITS-1:0] next,
    output logic                any
);

    logic [REQ_BITS-1:0] idx;

    // Scan from farthest to nearest so the closest requester after 'last' wins.
    always_comb begin
        next = '0;
        idx  = '0;
        any  = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = REQ_BITS'((int'(last) + k) % NUM_REQ);
            if (req[idx]) next = idx;
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin sharing of one 8-bit Avalon-MM SDRAM master among NUM_REQ tile controllers,
// one transfer outstanding at a time, with a read-response watchdog.
import gpu_mem_arbiter_pkg::*;

module gpu_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = $clog2(NUM_REQ),
    parameter int TIMEOUT  = 255
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ*32-1:0]           s_address,
    input  logic [NUM_REQ*8-1:0]            s_writedata,
    input  logic [NUM_REQ-1:0]              s_read,
    input  logic [NUM_REQ-1:0]              s_write,
    output logic [NUM_REQ-1:0]              s_waitrequest,
    output logic [AVALON_DATA_BITS-1:0]     s_readdata,
    output logic [NUM_REQ-1:0]              s_readdatavalid,
    output logic [31:0]                     m_address,
    output logic [AVALON_DATA_BITS-1:0]     m_writedata,
    output logic                            m_read,
    output logic                            m_write,
    input  logic                            m_waitrequest,
    input  logic [AVALON_DATA_BITS-1:0]     m_readdata,
    input  logic                            m_readdatavalid,
    output logic                            timeout_err,
    input  logic                            clear_err
);

    arb_state_e                  state;
    logic [REQ_BITS-1:0]         grant;
    logic [REQ_BITS-1:0]         last;
    logic [REQ_BITS-1:0]         pick;
    logic                        any;
    logic [WATCHDOG_BITS-1:0]    counter;
    logic [NUM_REQ-1:0]          req;
    logic [31:0]                 addr_a  [NUM_REQ];
    logic [AVALON_DATA_BITS-1:0] wdata_a [NUM_REQ];
    logic                        g_rd, g_wr, g_req;
    logic                        acc_rd_done, wait_rd_done, wait_timeout;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = s_address[32*i +: 32];
        assign wdata_a[i] = s_writedata[8*i +: 8];
    end

    assign req   = s_read | s_write;
    assign g_rd  = s_read[grant];
    assign g_wr  = s_write[grant];
    assign g_req = g_rd | g_wr;

    assign acc_rd_done  = (state == ACCESS) && g_rd && !m_waitrequest && m_readdatavalid;
    assign wait_rd_done = (state == WAIT_DATA) && m_readdatavalid;
    // Real data arriving on the timeout cycle beats the watchdog.
    assign wait_timeout = (state == WAIT_DATA) && !m_readdatavalid &&
                          (counter == WATCHDOG_BITS'(TIMEOUT));

    gpu_mem_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_pick (
        .req  (req),
        .last (last),
        .next (pick),
        .any  (any)
    );

    always_comb begin
        m_address       = '0;
        m_writedata     = '0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        s_waitrequest   = '1;
        s_readdatavalid = '0;
        s_readdata      = '0;
        if (state == ACCESS) begin
            m_address            = addr_a[grant];
            m_writedata          = wdata_a[grant];
            m_read               = g_rd;
            m_write              = g_wr & ~g_rd;
            s_waitrequest[grant] = m_waitrequest;
        end
        if (acc_rd_done || wait_rd_done) begin
            s_readdatavalid[grant] = 1'b1;
            s_readdata             = m_readdata;
        end else if (wait_timeout) begin
            s_readdatavalid[grant] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= REQ_BITS'(NUM_REQ - 1);
            counter     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant <= pick;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A requester that withdraws keeps its turn: 'last' is left alone.
                    if (!g_req) begin
                        state <= IDLE;
                    end else if (!m_waitrequest) begin
                        if (g_rd && !m_readdatavalid) begin
                            counter <= '0;
                            state   <= WAIT_DATA;
                        end else begin
                            last  <= grant;
                            state <= IDLE;
                        end
                    end
                end
                WAIT_DATA: begin
                    counter <= counter + 1'b1;
                    if (wait_rd_done || wait_timeout) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wait_timeout)   timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter with NUM_REQ=4 and an 8-cycle watchdog.
module tb_gpu_mem_arbiter;

    localparam int NUM_REQ = 4;

    logic                    clock;
    logic                    reset_n;
    logic [NUM_REQ*32-1:0]   s_address;
    logic [NUM_REQ*8-1:0]    s_writedata;
    logic [NUM_REQ-1:0]      s_read;
    logic [NUM_REQ-1:0]      s_write;
    logic [NUM_REQ-1:0]      s_waitrequest;
    logic [7:0]              s_readdata;
    logic [NUM_REQ-1:0]      s_readdatavalid;
    logic [31:0]             m_address;
    logic [7:0]              m_writedata;
    logic                    m_read;
    logic                    m_write;
    logic                    m_waitrequest;
    logic [7:0]              m_readdata;
    logic                    m_readdatavalid;
    logic                    timeout_err;
    logic                    clear_err;

    int compared   = 0;
    int mismatched = 0;

    gpu_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .timeout_err     (timeout_err),
        .clear_err       (clear_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_swait"}, 32'(s_waitrequest), 32'hF);
        chk({tag, "_srdv"},  32'(s_readdatavalid), 32'h0);
        chk({tag, "_srdata"}, 32'(s_readdata), 32'h0);
        chk({tag, "_mrd"},   32'(m_read), 32'h0);
        chk({tag, "_mwr"},   32'(m_write), 32'h0);
        chk({tag, "_maddr"}, m_address, 32'h0);
        chk({tag, "_mwdata"}, 32'(m_writedata), 32'h0);
        chk({tag, "_err"},   32'(timeout_err), 32'h0);
    endtask

    logic [7:0] rd_tab [5];

    initial begin
        rd_tab = '{8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h96};
        reset_n = 1'b0;
        s_address = '0;
        s_writedata = '0;
        s_read = '0;
        s_write = '0;
        m_waitrequest = 1'b0;
        m_readdata = '0;
        m_readdatavalid = 1'b0;
        clear_err = 1'b0;

        // Reset values
        tick(); tick();
        #2;
        chk_reset_outputs("rst");

        // Requester 2: two back-to-back writes with memory always ready
        tick();
        reset_n = 1'b1;
        s_write[2] = 1'b1;
        s_address[64 +: 32] = 32'h0000_0200;
        s_writedata[16 +: 8] = 8'h11;
        #2;
        chk("wr1_idle_mwr", 32'(m_write), 32'h0);
        chk("wr1_idle_swait", 32'(s_waitrequest), 32'hF);
        tick(); #2;
        chk("wr1_mwr", 32'(m_write), 32'h1);
        chk("wr1_mrd", 32'(m_read), 32'h0);
        chk("wr1_maddr", m_address, 32'h0000_0200);
        chk("wr1_mwdata", 32'(m_writedata), 32'h11);
        chk("wr1_swait", 32'(s_waitrequest), 32'b1011);
        tick();
        s_address[64 +: 32] = 32'h0000_0204;
        s_writedata[16 +: 8] = 8'h22;
        #2;
        chk("wr2_idle_mwr", 32'(m_write), 32'h0);
        chk("wr2_idle_swait", 32'(s_waitrequest), 32'hF);
        tick(); #2;
        chk("wr2_mwr", 32'(m_write), 32'h1);
        chk("wr2_maddr", m_address, 32'h0000_0204);
        chk("wr2_mwdata", 32'(m_writedata), 32'h22);
        chk("wr2_swait", 32'(s_waitrequest), 32'b1011);
        tick();
        s_write = '0;
        #2;
        chk("wr_done_swait", 32'(s_waitrequest), 32'hF);

        // Fresh reset, then all four read continuously: grants 0,1,2,3,0
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) s_address[32*i +: 32] = 32'h1000 + 32'(i * 16);
        s_read = 4'hF;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m_readdata = 8'hEE;
            #2;
            chk($sformatf("rr%0d_idle_srdv", k), 32'(s_readdatavalid), 32'h0);
            chk($sformatf("rr%0d_idle_swait", k), 32'(s_waitrequest), 32'hF);
            tick();
            m_readdata = rd_tab[k];
            #2;
            chk($sformatf("rr%0d_maddr", k), m_address, 32'h1000 + 32'((k % 4) * 16));
            chk($sformatf("rr%0d_mrd", k), 32'(m_read), 32'h1);
            chk($sformatf("rr%0d_swait", k), 32'(s_waitrequest), 32'(4'hF & ~(4'h1 << (k % 4))));
            chk($sformatf("rr%0d_srdv", k), 32'(s_readdatavalid), 32'(4'h1 << (k % 4)));
            chk($sformatf("rr%0d_srdata", k), 32'(s_readdata), 32'(rd_tab[k]));
            tick();
        end
        s_read = '0;
        m_readdatavalid = 1'b0;

        // Requester 3 read: memory stalls 3 cycles, data 2 cycles after accept
        s_read[3] = 1'b1;
        s_address[96 +: 32] = 32'h0000_0300;
        m_waitrequest = 1'b1;
        #2;
        chk("stall_idle_mrd", 32'(m_read), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick(); #2;
            chk($sformatf("stall%0d_mrd", c), 32'(m_read), 32'h1);
            chk($sformatf("stall%0d_swait", c), 32'(s_waitrequest), 32'hF);
        end
        tick();
        m_waitrequest = 1'b0;
        #2;
        chk("stall_acc_mrd", 32'(m_read), 32'h1);
        chk("stall_acc_maddr", m_address, 32'h0000_0300);
        chk("stall_acc_swait", 32'(s_waitrequest), 32'b0111);
        chk("stall_acc_srdv", 32'(s_readdatavalid), 32'h0);
        tick();
        s_read = '0;
        #2;
        chk("stall_w0_mrd", 32'(m_read), 32'h0);
        chk("stall_w0_swait", 32'(s_waitrequest), 32'hF);
        chk("stall_w0_srdv", 32'(s_readdatavalid), 32'h0);
        tick();
        m_readdatavalid = 1'b1;
        m_readdata = 8'h5A;
        #2;
        chk("stall_w1_srdv", 32'(s_readdatavalid), 32'b1000);
        chk("stall_w1_srdata", 32'(s_readdata), 32'h5A);
        tick();
        m_readdata = 8'h77;
        #2;
        chk("late_rdv_srdv", 32'(s_readdatavalid), 32'h0);
        chk("late_rdv_srdata", 32'(s_readdata), 32'h0);
        tick();
        m_readdatavalid = 1'b0;

        // Requester 1 read that never returns data: watchdog after 8 cycles
        s_read[1] = 1'b1;
        s_address[32 +: 32] = 32'h0000_0104;
        m_readdata = 8'hFF;
        tick(); #2;
        chk("to_acc_mrd", 32'(m_read), 32'h1);
        chk("to_acc_maddr", m_address, 32'h0000_0104);
        tick();
        s_read = '0;
        for (int c = 0; c < 8; c++) begin
            #2;
            chk($sformatf("to_w%0d_srdv", c), 32'(s_readdatavalid), 32'h0);
            tick();
        end
        #2;
        chk("to_fire_srdv", 32'(s_readdatavalid), 32'b0010);
        chk("to_fire_srdata", 32'(s_readdata), 32'h0);
        chk("to_fire_err_pre", 32'(timeout_err), 32'h0);
        tick(); #2;
        chk("to_err_set", 32'(timeout_err), 32'h1);
        chk("to_after_srdv", 32'(s_readdatavalid), 32'h0);
        tick(); #2;
        chk("to_err_sticky", 32'(timeout_err), 32'h1);
        tick();
        clear_err = 1'b1;
        #2;
        chk("to_err_before_clear", 32'(timeout_err), 32'h1);
        tick();
        clear_err = 1'b0;
        #2;
        chk("to_err_cleared", 32'(timeout_err), 32'h0);

        // Requester 1 asserts read and write together: treated as a read
        tick();
        s_read[1] = 1'b1;
        s_write[1] = 1'b1;
        s_address[32 +: 32] = 32'h0000_0100;
        s_writedata[8 +: 8] = 8'h77;
        m_waitrequest = 1'b1;
        tick(); #2;
        chk("rw_mrd", 32'(m_read), 32'h1);
        chk("rw_mwr", 32'(m_write), 32'h0);
        chk("rw_maddr", m_address, 32'h0000_0100);
        tick();
        s_read = '0;
        s_write = '0;
        #2;
        chk("rw_drop_mrd", 32'(m_read), 32'h0);
        chk("rw_drop_mwr", 32'(m_write), 32'h0);
        tick();
        m_waitrequest = 1'b0;

        // Reset asserted while waiting for read data
        s_read[0] = 1'b1;
        s_address[0 +: 32] = 32'h0000_00AA;
        tick(); #2;
        chk("rst_acc_mrd", 32'(m_read), 32'h1);
        tick();
        s_read = '0;
        #2;
        chk("rst_wait_mrd", 32'(m_read), 32'h0);
        m_readdatavalid = 1'b1;
        m_readdata = 8'h3C;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        tick();
        m_readdatavalid = 1'b0;
        reset_n = 1'b1;
        s_read = 4'hF;
        m_waitrequest = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) s_address[32*i +: 32] = 32'h2000 + 32'(i);
        #2;
        chk("rst_rel_idle_mrd", 32'(m_read), 32'h0);
        tick(); #2;
        chk("rst_rel_maddr", m_address, 32'h0000_2000);
        chk("rst_rel_mrd", 32'(m_read), 32'h1);
        tick();
        s_read = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
